// File: rtl/handshake_pkg.sv
// handshake_pkg: occupancy encoding shared by the producer and consumer
// ends of the valid/ready sample handshake.
package handshake_pkg;

   // Buffer occupancy; the encoding doubles as the level reported to users.
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } occ_e;

   localparam logic [1:0] OCC_LEVEL_MAX = 2'd2;

   // Occupancy state to numeric level (0..2).
   function automatic logic [1:0] occ_level(input occ_e s);
      return 2'(s);
   endfunction

endpackage

// File: rtl/sat_counter.sv
// sat_counter: saturating up-counter with synchronous clear.
// A clear in the same cycle as an increment leaves the count at 1, so an
// event coinciding with the clear is never lost.
module sat_counter #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             inc_i,
   input  logic             clr_i,
   output logic [WIDTH-1:0] count_o
);

   localparam logic [WIDTH-1:0] CNT_ZERO = {WIDTH{1'b0}};
   localparam logic [WIDTH-1:0] CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam logic [WIDTH-1:0] CNT_MAX  = {WIDTH{1'b1}};

   logic [WIDTH-1:0] count_r;

   // Count events, stick at all-ones, clear (or restart at 1) on clr_i.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         count_r <= CNT_ZERO;
      end else if (clr_i) begin
         count_r <= inc_i ? CNT_ONE : CNT_ZERO;
      end else if (inc_i && (count_r != CNT_MAX)) begin
         count_r <= count_r + CNT_ONE;
      end
   end

   assign count_o = count_r;

endmodule

// File: rtl/handshake_source.sv
// handshake_source: producer end of a valid/ready sample handshake with a
// 2-entry buffer and sticky dropped-sample flag.
// Optional feature macro: HANDSHAKE_SOURCE_OVF_CNT_EN builds the saturating
// dropped-load counter; without it ovf_count_o is tied to zero.
module handshake_source
   import handshake_pkg::*;
#(
   parameter int unsigned           WIDTH         = 24,
   parameter logic [WIDTH-1:0]      RESET_VALUE   = 24'h0,
   parameter int unsigned           OVF_CNT_WIDTH = 8
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     load_i,
   input  logic [WIDTH-1:0]         load_data_i,
   output logic                     valid_o,
   input  logic                     ready_i,
   output logic [WIDTH-1:0]         data_o,
   output logic [1:0]               level_o,
   output logic                     overflow_o,
   input  logic                     clr_ovf_i,
   output logic [OVF_CNT_WIDTH-1:0] ovf_count_o
);

   occ_e             state_r;
   logic             valid_r;
   logic [WIDTH-1:0] head_r;
   logic [WIDTH-1:0] tail_r;
   logic             overflow_r;
   logic             transfer_s;
   logic             drop_s;

   // Handshake events from the current registered state and inputs.
   always_comb begin
      transfer_s = valid_r && ready_i;
      drop_s     = load_i && (state_r == TWO) && !transfer_s;
   end

   // Occupancy FSM: head_r is the presented word, tail_r the second slot.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_r <= EMPTY;
         valid_r <= 1'b0;
         head_r  <= RESET_VALUE;
         tail_r  <= RESET_VALUE;
      end else begin
         case (state_r)
            EMPTY: begin
               if (load_i) begin
                  state_r <= ONE;
                  valid_r <= 1'b1;
                  head_r  <= load_data_i;
               end
            end
            ONE: begin
               case ({load_i, transfer_s})
                  2'b10: begin
                     state_r <= TWO;
                     tail_r  <= load_data_i;
                  end
                  2'b01: begin
                     state_r <= EMPTY;
                     valid_r <= 1'b0;
                  end
                  2'b11: begin
                     head_r <= load_data_i;
                  end
                  default: begin
                     state_r <= ONE;
                  end
               endcase
            end
            TWO: begin
               case ({load_i, transfer_s})
                  2'b01: begin
                     state_r <= ONE;
                     head_r  <= tail_r;
                  end
                  2'b11: begin
                     head_r <= tail_r;
                     tail_r <= load_data_i;
                  end
                  default: begin
                     // Idle or dropped load: hold everything.
                     state_r <= TWO;
                  end
               endcase
            end
            default: begin
               state_r <= EMPTY;
               valid_r <= 1'b0;
            end
         endcase
      end
   end

   // Sticky overflow flag; a drop in the clearing cycle keeps it set.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         overflow_r <= 1'b0;
      end else if (drop_s) begin
         overflow_r <= 1'b1;
      end else if (clr_ovf_i) begin
         overflow_r <= 1'b0;
      end
   end

`ifdef HANDSHAKE_SOURCE_OVF_CNT_EN
   sat_counter #(
      .WIDTH (OVF_CNT_WIDTH)
   ) u_ovf_cnt (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .inc_i   (drop_s),
      .clr_i   (clr_ovf_i),
      .count_o (ovf_count_o)
   );
`else
   assign ovf_count_o = {OVF_CNT_WIDTH{1'b0}};
`endif

   assign valid_o    = valid_r;
   assign data_o     = head_r;
   assign level_o    = occ_level(state_r);
   assign overflow_o = overflow_r;

endmodule

// File: tb/tb_handshake_source.sv
// tb_handshake_source: directed and random stimulus against a queue-based
// reference model of the 2-entry producer buffer.
module tb_handshake_source;

   localparam int W  = 24;
   localparam int CW = 8;
   localparam int CNT_SAT = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          load;
   logic [W-1:0]  ld;
   logic          ready;
   logic          clr;
   logic          valid;
   logic [W-1:0]  data;
   logic [1:0]    level;
   logic          ovf;
   logic [CW-1:0] cnt;

   int checks = 0;
   int errors = 0;

   // Reference model: FIFO contents, last word handed over, overflow state.
   logic [W-1:0] mq[$];
   logic [W-1:0] m_last;
   bit           m_ovf;
   int           m_cnt;

   always #5 clk = ~clk;

   handshake_source #(
      .WIDTH         (W),
      .RESET_VALUE   (24'h0),
      .OVF_CNT_WIDTH (CW)
   ) dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .load_i      (load),
      .load_data_i (ld),
      .valid_o     (valid),
      .ready_i     (ready),
      .data_o      (data),
      .level_o     (level),
      .overflow_o  (ovf),
      .clr_ovf_i   (clr),
      .ovf_count_o (cnt)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int exp_cnt();
`ifdef HANDSHAKE_SOURCE_OVF_CNT_EN
      return m_cnt;
`else
      return 0;
`endif
   endfunction

   task automatic model_reset();
      mq.delete();
      m_last = 24'h0;
      m_ovf  = 1'b0;
      m_cnt  = 0;
   endtask

   task automatic check_outputs(input string ctx);
      logic [W-1:0] exp_data;
      exp_data = (mq.size() != 0) ? mq[0] : m_last;
      chk({ctx, ".valid"}, 32'(valid), 32'(mq.size() != 0));
      chk({ctx, ".data"},  32'(data),  32'(exp_data));
      chk({ctx, ".level"}, 32'(level), 32'(mq.size()));
      chk({ctx, ".ovf"},   32'(ovf),   32'(m_ovf));
      chk({ctx, ".cnt"},   32'(cnt),   32'(exp_cnt()));
   endtask

   // One clock cycle: drive inputs, sample handshake, advance model, check.
   task automatic step(input string ctx, input bit l, input logic [W-1:0] d,
                       input bit r, input bit c);
      bit tr;
      bit drop;
      bit obs_tr;
      int sz;
      logic [W-1:0] obs_word;
      logic [W-1:0] popped;
      load = l; ld = d; ready = r; clr = c;
      #1;
      obs_tr   = valid && ready;
      obs_word = data;
      @(posedge clk);
      sz     = mq.size();
      tr     = (sz != 0) && r;
      popped = 24'h0;
      if (tr) begin
         popped = mq.pop_front();
         m_last = popped;
      end
      drop = l && (sz == 2) && !tr;
      if (l && !drop) mq.push_back(d);
      if (drop) begin
         m_ovf = 1'b1;
         m_cnt = c ? 1 : ((m_cnt == CNT_SAT) ? CNT_SAT : m_cnt + 1);
      end else if (c) begin
         m_ovf = 1'b0;
         m_cnt = 0;
      end
      chk({ctx, ".xfer"}, 32'(obs_tr), 32'(tr));
      if (tr) chk({ctx, ".order"}, 32'(obs_word), 32'(popped));
      #1;
      check_outputs(ctx);
   endtask

   initial begin
      rst_n = 1'b0; load = 1'b0; ld = 24'h0; ready = 1'b0; clr = 1'b0;
      model_reset();

      // Reset held: load pulses must be ignored.
      for (int i = 0; i < 4; i++) begin
         load = (i % 2 == 0); ld = 24'h5A5A5A; ready = 1'b1;
         @(posedge clk);
         #1;
         check_outputs("reset");
      end
      load = 1'b0; ready = 1'b0;
      rst_n = 1'b1;

      // Single word under stall, then one transfer.
      step("single.load", 1'b1, 24'hABCDEF, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) step("single.stall", 1'b0, 24'h0, 1'b0, 1'b0);
      step("single.xfer", 1'b0, 24'h0, 1'b1, 1'b0);
      step("single.idle", 1'b0, 24'h0, 1'b1, 1'b0);

      // Backpressure fill and drop.
      step("fill.1", 1'b1, 24'h000001, 1'b0, 1'b0);
      step("fill.2", 1'b1, 24'h000002, 1'b0, 1'b0);
      step("fill.drop", 1'b1, 24'h000003, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) step("fill.drain", 1'b0, 24'h0, 1'b1, 1'b0);
      step("fill.clr", 1'b0, 24'h0, 1'b0, 1'b1);

      // Streaming at full rate.
      for (int i = 0; i < 100; i++) step("stream", 1'b1, 24'(i), 1'b1, 1'b0);
      step("stream.tail", 1'b0, 24'h0, 1'b1, 1'b0);

      // Load coinciding with transfer while full.
      step("both.1", 1'b1, 24'h000001, 1'b0, 1'b0);
      step("both.2", 1'b1, 24'h000002, 1'b0, 1'b0);
      step("both.3", 1'b1, 24'h000003, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) step("both.drain", 1'b0, 24'h0, 1'b1, 1'b0);

      // Saturation, then clear racing a drop, then plain clear.
      step("sat.fill", 1'b1, 24'h0000AA, 1'b0, 1'b0);
      step("sat.fill", 1'b1, 24'h0000BB, 1'b0, 1'b0);
      for (int i = 0; i < 300; i++) step("sat.drop", 1'b1, 24'($urandom), 1'b0, 1'b0);
`ifdef HANDSHAKE_SOURCE_OVF_CNT_EN
      chk("sat.value", 32'(cnt), 32'h0000_00FF);
`else
      chk("sat.value", 32'(cnt), 32'h0000_0000);
`endif
      step("race.clr_drop", 1'b1, 24'h0000CC, 1'b0, 1'b1);
      step("race.clr", 1'b0, 24'h0, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) step("sat.drain", 1'b0, 24'h0, 1'b1, 1'b0);

      // Randomized traffic.
      for (int i = 0; i < 500; i++)
         step("rand", 1'($urandom_range(0, 1)), 24'($urandom),
              ($urandom_range(0, 3) != 0), ($urandom_range(0, 31) == 0));

      // Asynchronous reset with words buffered mid-transfer.
      step("mid.1", 1'b1, 24'h111111, 1'b0, 1'b0);
      step("mid.2", 1'b1, 24'h222222, 1'b0, 1'b0);
      step("mid.3", 1'b1, 24'h333333, 1'b0, 1'b0);
      ready = 1'b1;
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      check_outputs("mid.reset");
      @(posedge clk);
      #1;
      check_outputs("mid.held");
      rst_n = 1'b1;
      step("mid.after", 1'b0, 24'h0, 1'b1, 1'b0);
      step("mid.reload", 1'b1, 24'h444444, 1'b0, 1'b0);
      step("mid.out", 1'b0, 24'h0, 1'b1, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/handshake_source.md
# handshake_source

Producer end of the valid/ready sample handshake: captures a word on a one-cycle load strobe (e.g. ADC conversion done) and presents it on valid/data until the downstream consumer accepts it. A 2-entry buffer absorbs one cycle of backpressure without losing samples, and a sticky flag records dropped samples. It sits between the sample-capture logic and any always-ready or stalling consumer on the sample path.

## Interface
- WIDTH, 24, data word width
- RESET_VALUE, 24'h0, value of data_o after reset
- OVF_CNT_WIDTH, 8, width of dropped-sample counter
- clk_i  in  1  single clock
- rst_ni  in  1  asynchronous, active-low reset
- load_i  in  1  one-cycle strobe: capture load_data_i
- load_data_i  in  WIDTH  word to enqueue
- valid_o  out  1  data_o holds an unaccepted word
- ready_i  in  1  consumer accepts when high with valid_o
- data_o  out  WIDTH  head word, registered
- level_o  out  2  occupancy, 0..2
- overflow_o  out  1  sticky: a load was dropped
- clr_ovf_i  in  1  clears overflow_o and ovf_count_o
- ovf_count_o  out  OVF_CNT_WIDTH  saturating dropped-load count

## Operation
- States by occupancy: EMPTY (0), ONE (1), TWO (2); level_o is the encoded state.
- Transfer = valid_o && ready_i. Load accepted = load_i && (state != TWO || transfer).
- EMPTY: load -> ONE, data_o <= load_data_i. ready_i ignored (valid_o low).
- ONE: load only -> TWO, word into second slot. Transfer only -> EMPTY. Both -> ONE, data_o <= load_data_i.
- TWO: transfer only -> ONE, data_o <= second slot. Both -> TWO, second slot moves to head, load_data_i into second slot. Load only -> dropped, state unchanged, overflow event.
- Order preserved: words leave in load order; none duplicated.
- Stability: while valid_o && !ready_i, data_o and valid_o unchanged.
- On EMPTY, data_o holds the last transferred word (RESET_VALUE after reset).
- Overflow event: overflow_o <= 1; ovf_count_o increments, saturates at all-ones.
- clr_ovf_i: overflow_o <= 0, ovf_count_o <= 0. Simultaneous overflow event wins: overflow_o = 1, ovf_count_o = 1.

## Timing
- Reset (rst_ni low, asynchronous): state EMPTY, valid_o 0, level_o 0, data_o RESET_VALUE, overflow_o 0, ovf_count_o 0. Reset mid-transfer discards all buffered words.
- Load-to-valid latency: 1 cycle (load in cycle N, valid_o high in cycle N+1).
- Transfer-to-next-word: 0 bubble; with TWO, next word on data_o in the cycle after transfer.
- Sustained throughput: one word per cycle when ready_i held high.
- All outputs registered; no combinational path from ready_i or load_i to any output.

## Configuration
- HANDSHAKE_SOURCE_OVF_CNT_EN defined: saturating counter built, ovf_count_o behaves as above.
- Not defined: counter omitted, ovf_count_o tied to 0; overflow_o and clr_ovf_i unchanged.

## Structure
- Shared package handshake_pkg: occupancy typedef (EMPTY/ONE/TWO, 2-bit) and its constants, shared with consumer-side blocks.
- One sub-module: sat_counter (parameterised width, inc/clr, clear-with-inc yields 1), instantiated only under HANDSHAKE_SOURCE_OVF_CNT_EN.

## Test plan
- Reset: hold rst_ni low, pulse load_i -> valid_o 0, data_o 24'h0, level_o 0, overflow_o 0 throughout.
- Single word: load 24'hABCDEF with ready_i low -> valid_o high next cycle, data_o stable 24'hABCDEF for 5 stall cycles; raise ready_i -> one transfer, level_o returns 0.
- Backpressure fill: loads 24'h000001, 24'h000002 with ready_i low -> level_o 2; third load 24'h000003 -> dropped, overflow_o 1, ovf_count_o 1; release ready_i -> outputs 1 then 2 only.
- Streaming: ready_i high, load every cycle with 0..99 -> 100 transfers in order, level_o never exceeds 1, overflow_o 0.
- Simultaneous at TWO: load 24'h000003 in the same cycle as a transfer -> accepted, level_o stays 2, order 1,2,3, no overflow.
- Clear race and saturation: 300 drops -> ovf_count_o 8'hFF (macro on) or 0 (macro off); clr_ovf_i with concurrent drop -> overflow_o 1, ovf_count_o 1.
